// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state type and default width for the bit-serial subtractor
package serial_sub_pkg;
  localparam int SUB_WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit combinational subtractor cell (a - b - bin)
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_ripple_borrow_sub.sv
// serial_ripple_borrow_sub: LSB-first bit-serial A - B - BIN with valid/ready handshakes; SERIAL_SUB_OVF_EN adds signed overflow output OVF
module serial_ripple_borrow_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic [WIDTH-1:0] BOUT
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic bw, d_bit, bout_bit;
  logic accept;
  assign accept = (state == IDLE) && in_valid;
  full_subtractor_bit u_bit (
    .a   (a_reg[cnt]),
    .b   (b_reg[cnt]),
    .bin (bw),
    .d   (d_bit),
    .bout(bout_bit)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    state_nxt = in_valid ? BUSY : IDLE;
      BUSY:    state_nxt = (cnt == LAST) ? DONE : BUSY;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // operand capture and one result bit per BUSY cycle through the shared cell
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      DIFF  <= '0;
      BOUT  <= '0;
`ifdef SERIAL_SUB_OVF_EN
      OVF   <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= A;
      b_reg <= B;
      bw    <= BIN;
      cnt   <= '0;
      DIFF  <= '0;
      BOUT  <= '0;
`ifdef SERIAL_SUB_OVF_EN
      OVF   <= 1'b0;
`endif
    end else if (state == BUSY) begin
      DIFF[cnt] <= d_bit;
      BOUT[cnt] <= bout_bit;
      bw        <= bout_bit;
      if (cnt != LAST) cnt <= cnt + CW'(1);
`ifdef SERIAL_SUB_OVF_EN
      if (cnt == LAST) OVF <= bw ^ bout_bit;
`endif
    end
  end
endmodule

// File: tb/tb_serial_ripple_borrow_sub.sv
// tb_serial_ripple_borrow_sub: directed and random checks of the serial subtractor against an arithmetic model
module tb_serial_ripple_borrow_sub;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, BIN = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] A = '0, B = '0, DIFF, BOUT;
`ifdef SERIAL_SUB_OVF_EN
  logic OVF;
`endif
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  serial_ripple_borrow_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .BIN      (BIN),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .DIFF     (DIFF),
    .BOUT     (BOUT)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF      (OVF)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] m_diff(input int a, input int b, input int bin);
    return W'(a - b - bin);
  endfunction
  function automatic logic [W-1:0] m_bout(input int a, input int b, input int bin);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (a % (1 << (i + 1))) < (b % (1 << (i + 1))) + bin;
    return r;
  endfunction
  function automatic logic m_ovf(input int a, input int b, input int bin);
    int sa, sb, s;
    sa = a >= (1 << (W - 1)) ? a - (1 << W) : a;
    sb = b >= (1 << (W - 1)) ? b - (1 << W) : b;
    s  = sa - sb - bin;
    return (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endfunction
  task automatic wait_result(input string tag, input int a, input int b, input int bin, input bit tog);
    int n = 0;
    while (!out_valid && n < 20) begin
      if (tog) begin
        A = W'($urandom);
        B = W'($urandom);
        BIN = 1'($urandom);
        in_valid = 1'($urandom);
      end
      tick;
      n++;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_diff"}, DIFF, m_diff(a, b, bin));
    check({tag, "_bout"}, BOUT, m_bout(a, b, bin));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, OVF, m_ovf(a, b, bin));
`endif
  endtask
  task automatic run_op(input string tag, input int a, input int b, input int bin, input int hold, input bit tog);
    A = W'(a);
    B = W'(b);
    BIN = 1'(bin);
    in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick;
    in_valid = 1'b0;
    wait_result(tag, a, b, bin, tog);
    in_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_diff"}, DIFF, m_diff(a, b, bin));
      check({tag, "_hold_bout"}, BOUT, m_bout(a, b, bin));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 0);
    check({tag, "_back_idle"}, in_ready, 1);
  endtask
  initial begin
    int qa, qb, qc, last;
    tick;
    tick;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", DIFF, 0);
    check("rst_bout", BOUT, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", OVF, 0);
`endif
    rst_n = 1'b1;
    tick;
    run_op("a9b3", 9, 3, 0, 0, 0);
    run_op("a3b9", 3, 9, 0, 0, 0);
    run_op("a0b0bin1", 0, 0, 1, 0, 0);
    run_op("a7b7bin1", 7, 7, 1, 0, 0);
    run_op("a15b0", 15, 0, 0, 0, 0);
    run_op("backpressure", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 10, 1);
    A = 4'd6;
    B = 4'd11;
    BIN = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", DIFF, 0);
    check("abort_bout", BOUT, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("abort_no_valid", out_valid, 0);
    end
    run_op("after_abort", 12, 5, 1, 0, 0);
    out_ready = 1'b1;
    A = W'($urandom);
    B = W'($urandom);
    BIN = 1'($urandom);
    in_valid = 1'b1;
    last = 0;
    for (int k = 0; k < 10; k++) begin
      check("b2b_in_ready", in_ready, 1);
      qa = int'(A);
      qb = int'(B);
      qc = int'(BIN);
      tick;
      if (k > 0) check("b2b_period", cyc - last, W + 2);
      last = cyc;
      A = W'($urandom);
      B = W'($urandom);
      BIN = 1'($urandom);
      wait_result("b2b", qa, qb, qc, 0);
      check("b2b_final_borrow", BOUT[W-1], qa < qb + qc);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
